// File: rtl/arith_pkg.sv
// arith_pkg: shared types and constants for the arithmetic library.
//   state_t       : sequencer states of the iterative arithmetic blocks
//   DEFAULT_WIDTH : operand width shared with the ripple adder
//   CNT_W         : bit-counter width for DEFAULT_WIDTH
//   cnt_w()       : bit-counter width for an arbitrary operand width
package arith_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int DEFAULT_WIDTH = 4;
   localparam int CNT_W = $clog2(DEFAULT_WIDTH);
   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction
endpackage

// File: rtl/fs_cell.sv
// fs_cell: combinational 1-bit full subtractor computing a - b - bin.
//   a, b : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, one bit per clock LSB first, with valid/ready handshakes.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake, A and B captured on the accept edge
//   out_valid/out_ready : result handshake
//   D, borrow, zero   : difference mod 2^WIDTH, A < B flag, D == 0 flag
//   busy              : high while bits are being processed
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             borrow,
   output logic             zero,
   output logic             busy
);
   localparam int CW = cnt_w(WIDTH);
   state_t state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
   logic [CW-1:0] cnt;
   logic br, d_bit, br_next, last;
   fs_cell u_fs (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .bin (br),
      .d   (d_bit),
      .bout(br_next)
   );
   // difference bits enter at the MSB so the LSB-first result lands aligned after WIDTH shifts
   assign r_next = {d_bit, r_sh[WIDTH-1:1]};
   assign last   = cnt == CW'(WIDTH - 1);
   always_comb begin
      state_next = state;
      in_ready   = state == IDLE;
      busy       = state == RUN;
      out_valid  = state == DONE;
      state_next = (state == IDLE && in_valid) ? RUN  :
                   (state == RUN  && last)     ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         r_sh   <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         D      <= '0;
         borrow <= 1'b0;
         zero   <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && in_valid) begin
            a_sh <= A;
            b_sh <= B;
            br   <= 1'b0;
            cnt  <= '0;
         end
         if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= r_next;
            br   <= br_next;
            cnt  <= cnt + 1'b1;
            if (last) begin
               D      <= r_next;
               borrow <= br_next;
               zero   <= r_next == '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: checks serial_subtractor against a timestamp/arithmetic model.
module tb_serial_subtractor;
   localparam int W = 4;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0] A = '0, B = '0;
   logic in_ready, out_valid, borrow, zero, busy;
   logic [W-1:0] D;
   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .D(D), .borrow(borrow), .zero(zero), .busy(busy)
   );
   always #5 clk = ~clk;
   int vectors = 0, miscompares = 0;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", n, act, exp, $time);
      end
   endtask
   // model: an op is pending from its accept edge; e counts edges since accept,
   // the result appears after W edges and stays until the handshake edge
   logic pend = 1'b0, en = 1'b0;
   int e = 0, cyc = 0, last_acc = -1, acc_cnt = 0, res_cnt = 0;
   logic [W-1:0] ma = '0, mb = '0, md = '0;
   logic mbo = 1'b0, mz = 1'b0;
   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         pend = 1'b0; md = '0; mbo = 1'b0; mz = 1'b0; en = 1'b1; last_acc = -1;
      end else if (!pend) begin
         if (in_valid) begin
            pend = 1'b1; e = 0; ma = A; mb = B; acc_cnt++;
            if (last_acc >= 0) chk("accept_interval", 32'(cyc - last_acc >= W + 2), 1);
            last_acc = cyc;
         end
      end else if (e >= W) begin
         if (out_ready) begin pend = 1'b0; res_cnt++; end
      end else begin
         e++;
         if (e == W) begin
            md = ma - mb; mbo = ma < mb; mz = (ma - mb) == '0;
         end
      end
   end
   always @(negedge clk) if (en) begin
      chk("in_ready", 32'(in_ready), 32'(!pend));
      chk("busy", 32'(busy), 32'(pend && e < W));
      chk("out_valid", 32'(out_valid), 32'(pend && e >= W));
      chk("D", 32'(D), 32'(md));
      chk("borrow", 32'(borrow), 32'(mbo));
      chk("zero", 32'(zero), 32'(mz));
   end
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int t = acc_cnt;
      A = a; B = b; in_valid = 1'b1;
      for (int i = 0; i < 50 && acc_cnt == t; i++) tick();
      if (acc_cnt == t) chk("accept_timeout", 0, 1);
      in_valid = 1'b0; A = W'($urandom); B = W'($urandom);
   endtask
   task automatic wait_valid();
      for (int i = 0; i < 50 && !(pend && e >= W); i++) tick();
      if (!(pend && e >= W)) chk("valid_timeout", 0, 1);
   endtask
   task automatic drain();
      int t = res_cnt;
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 50 && res_cnt == t; i++) tick();
      if (res_cnt == t) chk("handoff_timeout", 0, 1);
      out_ready = 1'b0;
   endtask
   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ed,
                      input logic eb, input logic ez, input int stall);
      int kc;
      out_ready = (stall == 0);
      send(a, b);
      kc = last_acc;
      wait_valid();
      chk("latency", 32'(cyc - kc), W);
      chk("lit_D", 32'(D), 32'(ed));
      chk("lit_borrow", 32'(borrow), 32'(eb));
      chk("lit_zero", 32'(zero), 32'(ez));
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; A = W'($urandom); B = W'($urandom);
         tick();
         chk("held_D", 32'(D), 32'(ed));
         chk("held_in_ready", 32'(in_ready), 0);
      end
      drain();
      chk("idle_in_ready", 32'(in_ready), 1);
      chk("idle_out_valid", 32'(out_valid), 0);
   endtask
   initial begin
      tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_D", 32'(D), 0);
      run(4'd9, 4'd3, 4'h6, 1'b0, 1'b0, 0);
      run(4'd3, 4'd9, 4'hA, 1'b1, 1'b0, 0);
      run(4'd0, 4'd1, 4'hF, 1'b1, 1'b0, 0);
      run(4'd15, 4'd15, 4'h0, 1'b0, 1'b1, 0);
      run(4'd0, 4'd0, 4'h0, 1'b0, 1'b1, 0);
      run(4'd12, 4'd5, 4'h7, 1'b0, 1'b0, 5);
      send(4'd10, 4'd4);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_D", 32'(D), 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      for (int i = 0; i < 8; i++) tick();
      run(4'd8, 4'd8, 4'h0, 1'b0, 1'b1, 0);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(W'(a), W'(b));
            wait_valid();
            repeat ($urandom_range(0, 3)) begin
               in_valid = 1'($urandom); tick();
            end
            drain();
         end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
